svo_stream_check: RTL and testbench
===================================

# svo_stream_check

Sink-side checker for SVO pixel streams. It consumes an AXI-stream video stream that uses tuser[0] as start-of-frame, and tracks the raster position. It verifies that start-of-frame markers sit on pixel (0,0) and computes a 32-bit per-frame signature. In the design it terminates any SVO video source (test card, framebuffer reader) in simulation and on-chip self-test. It can also generate pseudo-random backpressure to exercise producer handshakes.

## Interface
Parameters:
- SVO_HOR_PIXELS, 640, active pixels per line (≥2)
- SVO_VER_PIXELS, 480, active lines per frame (≥1)
- SVO_BITS_PER_PIXEL, 24, tdata width (1..32)
- STALL_EN, 0, 1 = drive tready from LFSR, 0 = always ready

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- in_axis_tvalid  in  1  pixel valid
- in_axis_tready  out  1  pixel accepted when tvalid && tready
- in_axis_tdata  in  SVO_BITS_PER_PIXEL  pixel
- in_axis_tuser  in  1  start of frame
- locked  out  1  stream is aligned to frame grid
- frame_done  out  1  one-cycle pulse, full frame accepted
- frame_sig  out  32  signature of last completed frame
- frame_count  out  16  completed frames, wraps
- err_count  out  16  alignment errors, saturates at 0xFFFF
- err_sof_early  out  1  one-cycle pulse, SOF at non-(0,0) position
- err_sof_missing  out  1  one-cycle pulse, (0,0) position without SOF

## Operation
- Beat = clock edge with in_axis_tvalid && in_axis_tready. All state changes happen only on beats, except the LFSR and the pulse clears.
- Counters: hcur (0..SVO_HOR_PIXELS-1) and vcur (0..SVO_VER_PIXELS-1). They give the position of the next expected beat.
- State SEARCH (after reset):
  - Beats with tuser=0 are discarded.
  - A beat with tuser=1 is taken as pixel (0,0): locked<=1, sig<=d, hcur<=1, vcur<=0, go LOCKED.
- State LOCKED, beat at expected position (hcur,vcur):
  - tuser=1 and position (0,0): normal. sig restarts: sig_next = d.
  - tuser=1 and position ≠ (0,0): err_sof_early pulse, err_count+1. Resync: treat the beat as pixel (0,0), sig_next = d, hcur<=1, vcur<=0. Stay LOCKED. No frame_done for the aborted frame.
  - tuser=0 and position (0,0): err_sof_missing pulse, err_count+1, locked<=0, go SEARCH. The beat is discarded.
  - Otherwise: sig_next = {sig[30:0],sig[31]} ^ d.
- d = in_axis_tdata zero-extended to 32 bits.
- Position advance: hcur wraps at SVO_HOR_PIXELS-1 and increments vcur; vcur wraps at SVO_VER_PIXELS-1 to 0.
- Last pixel of a frame (hcur=H-1, vcur=V-1, valid beat in LOCKED):
  - frame_sig<=sig_next
  - frame_done pulse
  - frame_count+1, wrapping 0xFFFF→0
  - Counters return to (0,0).
- Backpressure:
  - STALL_EN=0: tready is 1 every cycle after reset.
  - STALL_EN=1: a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 0xACE1 at reset) shifts every cycle. tready <= lfsr[0] | lfsr[1], registered.

## Timing
- All outputs are registered. Reset values: in_axis_tready=0, locked=0, frame_done=0, frame_sig=0, frame_count=0, err_count=0, both error pulses=0.
- tready is 0 in the first cycle after reset is released. It follows its source from the second cycle.
- Latency: frame_done, frame_sig, frame_count, err_* and locked all update on the same edge as the triggering beat. They are visible in the following cycle.
- Pulses last exactly one cycle. Back-to-back triggering beats give back-to-back pulses.
- Inputs are ignored while tready=0, or while tvalid=0. The producer is expected to hold tdata/tuser stable; no check is made.
- Reset mid-frame: all state returns to reset values on the next edge with resetn=0. The partial frame is dropped with no error or pulse.
- err_count saturation: at 0xFFFF, further errors still pulse but the count does not change.
- Edge case SVO_VER_PIXELS=1: the last pixel is the beat where hcur=H-1. The SOF beat can never also be a last pixel, because SVO_HOR_PIXELS≥2.

## Test plan
- Reset: hold resetn=0 for 3 cycles -> all outputs 0; tready=0 then 1 (STALL_EN=0).
- Clean frames, H=4, V=2, tdata=1 always, tuser=1 on every 8th beat -> frame_done every 8 beats; frame_sig=0x000000FF; frame_count 1,2,3; err_count=0; locked=1 after the first SOF.
- Early SOF, H=4, V=2: SOF, 4 beats, then SOF -> err_sof_early pulse, err_count=1. Next frame done 8 beats after the second SOF with sig=0xFF.
- Missing SOF: 8-beat frame, then 8 beats all with tuser=0 -> frame_done after the first frame. err_sof_missing on beat 9, locked=0; no further frame_done until the next SOF.
- STALL_EN=1, source holds tvalid=1 with ramp data 0..7 per frame -> tready shows the LFSR pattern. frame_sig equals the reference model sum over accepted beats only. No errors.
- Reset asserted after 5 beats of a frame, then a clean frame -> no pulses during reset. frame_count=1 after the clean frame; err_count=0.

Source files
------------

// File: rtl/svo_stream_check.sv
// svo_stream_check: sink-side checker for SVO AXI-stream video.
// Tracks raster position, checks that start-of-frame markers land on (0,0),
// accumulates a 32-bit rotate-xor signature per frame and can apply
// pseudo-random backpressure to exercise the producer's handshake.
module svo_stream_check #(
    parameter int SVO_HOR_PIXELS     = 640,
    parameter int SVO_VER_PIXELS     = 480,
    parameter int SVO_BITS_PER_PIXEL = 24,
    parameter int STALL_EN           = 0
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          in_axis_tvalid,
    output logic                          in_axis_tready,
    input  logic [SVO_BITS_PER_PIXEL-1:0] in_axis_tdata,
    input  logic                          in_axis_tuser,
    output logic                          locked,
    output logic                          frame_done,
    output logic [31:0]                   frame_sig,
    output logic [15:0]                   frame_count,
    output logic [15:0]                   err_count,
    output logic                          err_sof_early,
    output logic                          err_sof_missing
);

    localparam int HW = (SVO_HOR_PIXELS > 1) ? $clog2(SVO_HOR_PIXELS) : 1;
    localparam int VW = (SVO_VER_PIXELS > 1) ? $clog2(SVO_VER_PIXELS) : 1;
    localparam logic [HW-1:0] H_LAST = HW'(SVO_HOR_PIXELS - 1);
    localparam logic [VW-1:0] V_LAST = VW'(SVO_VER_PIXELS - 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t        state;
    logic [15:0]   lfsr;
    logic [HW-1:0] hcur;
    logic [VW-1:0] vcur;
    logic [31:0]   sig;

    logic          beat;
    logic [31:0]   d;
    logic [31:0]   sig_step;
    logic          at_origin;
    logic          at_last;
    logic [HW-1:0] hcur_adv;
    logic [VW-1:0] vcur_adv;

    // Beat qualification, signature step and next raster position.
    always_comb begin
        beat      = in_axis_tvalid && in_axis_tready;
        d         = 32'(in_axis_tdata);
        sig_step  = {sig[30:0], sig[31]} ^ d;
        at_origin = (hcur == '0) && (vcur == '0);
        at_last   = (hcur == H_LAST) && (vcur == V_LAST);
        hcur_adv  = hcur + HW'(1);
        vcur_adv  = vcur;
        if (hcur == H_LAST) begin
            hcur_adv = '0;
            vcur_adv = (vcur == V_LAST) ? '0 : vcur + VW'(1);
        end
    end

    // Backpressure source: free-running LFSR, tready registered from it
    // (or held high when stalling is disabled). Low for one cycle after reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lfsr           <= 16'hACE1;
            in_axis_tready <= 1'b0;
        end else begin
            lfsr           <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            in_axis_tready <= (STALL_EN != 0) ? (lfsr[0] | lfsr[1]) : 1'b1;
        end
    end

    // Frame alignment FSM, signature and counters; only beats change state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state           <= SEARCH;
            locked          <= 1'b0;
            hcur            <= '0;
            vcur            <= '0;
            sig             <= '0;
            frame_done      <= 1'b0;
            frame_sig       <= '0;
            frame_count     <= '0;
            err_count       <= '0;
            err_sof_early   <= 1'b0;
            err_sof_missing <= 1'b0;
        end else begin
            frame_done      <= 1'b0;
            err_sof_early   <= 1'b0;
            err_sof_missing <= 1'b0;
            if (beat) begin
                case (state)
                    SEARCH: begin
                        // Anything before the first SOF is ignored.
                        if (in_axis_tuser) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                            sig    <= d;
                            hcur   <= HW'(1);
                            vcur   <= '0;
                        end
                    end
                    LOCKED: begin
                        if (in_axis_tuser) begin
                            // SOF always restarts the frame; off-grid SOF resyncs.
                            if (!at_origin) begin
                                err_sof_early <= 1'b1;
                                if (err_count != 16'hFFFF)
                                    err_count <= err_count + 16'd1;
                            end
                            sig  <= d;
                            hcur <= HW'(1);
                            vcur <= '0;
                        end else if (at_origin) begin
                            // Expected SOF not seen: drop lock, discard beat.
                            err_sof_missing <= 1'b1;
                            if (err_count != 16'hFFFF)
                                err_count <= err_count + 16'd1;
                            locked <= 1'b0;
                            state  <= SEARCH;
                        end else begin
                            sig  <= sig_step;
                            hcur <= hcur_adv;
                            vcur <= vcur_adv;
                            if (at_last) begin
                                frame_done  <= 1'b1;
                                frame_sig   <= sig_step;
                                frame_count <= frame_count + 16'd1;
                            end
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_svo_stream_check.sv
// Bench for svo_stream_check: two 4x2 instances, one always-ready and one
// with LFSR backpressure, checked every cycle against a linear-position
// frame model.
module tb_svo_stream_check;

    localparam int H = 4;
    localparam int V = 2;
    localparam int N = H * V;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    logic tv0 = 1'b0, tu0 = 1'b0;
    logic [7:0] td0 = 8'd0;
    logic tr0, lk0, fd0, ee0, em0;
    logic [31:0] fs0;
    logic [15:0] fc0, ec0;

    logic tv1 = 1'b0, tu1 = 1'b0;
    logic [7:0] td1 = 8'd0;
    logic tr1, lk1, fd1, ee1, em1;
    logic [31:0] fs1;
    logic [15:0] fc1, ec1;

    int tests = 0;
    int fails = 0;

    // reference model state, index 0 = dut0, 1 = dut1
    bit          m_tr[2], m_lk[2], m_fd[2], m_ee[2], m_em[2], m_beat[2];
    int          m_pos[2];
    logic [31:0] m_sig[2], m_fs[2];
    logic [15:0] m_fc[2], m_ec[2];
    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    svo_stream_check #(.SVO_HOR_PIXELS(H), .SVO_VER_PIXELS(V),
                       .SVO_BITS_PER_PIXEL(8), .STALL_EN(0)) dut0 (
        .clk(clk), .resetn(resetn),
        .in_axis_tvalid(tv0), .in_axis_tready(tr0),
        .in_axis_tdata(td0), .in_axis_tuser(tu0),
        .locked(lk0), .frame_done(fd0), .frame_sig(fs0),
        .frame_count(fc0), .err_count(ec0),
        .err_sof_early(ee0), .err_sof_missing(em0)
    );

    svo_stream_check #(.SVO_HOR_PIXELS(H), .SVO_VER_PIXELS(V),
                       .SVO_BITS_PER_PIXEL(8), .STALL_EN(1)) dut1 (
        .clk(clk), .resetn(resetn),
        .in_axis_tvalid(tv1), .in_axis_tready(tr1),
        .in_axis_tdata(td1), .in_axis_tuser(tu1),
        .locked(lk1), .frame_done(fd1), .frame_sig(fs1),
        .frame_count(fc1), .err_count(ec1),
        .err_sof_early(ee1), .err_sof_missing(em1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_one(input int i, input logic v, input logic u, input logic [7:0] dd);
        logic [31:0] d;
        d = {24'd0, dd};
        m_fd[i] = 0; m_ee[i] = 0; m_em[i] = 0;
        m_beat[i] = v && m_tr[i];
        if (m_beat[i]) begin
            if (!m_lk[i]) begin
                if (u) begin m_lk[i] = 1; m_sig[i] = d; m_pos[i] = 1; end
            end else if (u) begin
                if (m_pos[i] != 0) begin
                    m_ee[i] = 1;
                    if (m_ec[i] != 16'hFFFF) m_ec[i] = m_ec[i] + 16'd1;
                end
                m_sig[i] = d;
                m_pos[i] = 1;
            end else if (m_pos[i] == 0) begin
                m_em[i] = 1;
                if (m_ec[i] != 16'hFFFF) m_ec[i] = m_ec[i] + 16'd1;
                m_lk[i] = 0;
            end else begin
                m_sig[i] = ((m_sig[i] << 1) | (m_sig[i] >> 31)) ^ d;
                if (m_pos[i] == N - 1) begin
                    m_fd[i] = 1;
                    m_fs[i] = m_sig[i];
                    m_fc[i] = m_fc[i] + 16'd1;
                    m_pos[i] = 0;
                end else begin
                    m_pos[i] = m_pos[i] + 1;
                end
            end
        end
    endtask

    task automatic model_update();
        if (!resetn) begin
            for (int i = 0; i < 2; i++) begin
                m_tr[i] = 0; m_lk[i] = 0; m_fd[i] = 0; m_ee[i] = 0; m_em[i] = 0;
                m_beat[i] = 0; m_pos[i] = 0; m_sig[i] = 0; m_fs[i] = 0;
                m_fc[i] = 0; m_ec[i] = 0;
            end
            m_lfsr = 16'hACE1;
        end else begin
            model_one(0, tv0, tu0, td0);
            model_one(1, tv1, tu1, td1);
            m_tr[0] = 1;
            m_tr[1] = m_lfsr[0] | m_lfsr[1];
            m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        end
    endtask

    task automatic check_all();
        chk("tready0", 32'(tr0), 32'(m_tr[0]));
        chk("locked0", 32'(lk0), 32'(m_lk[0]));
        chk("done0",   32'(fd0), 32'(m_fd[0]));
        chk("sig0",    fs0,      m_fs[0]);
        chk("fcount0", 32'(fc0), 32'(m_fc[0]));
        chk("ecount0", 32'(ec0), 32'(m_ec[0]));
        chk("early0",  32'(ee0), 32'(m_ee[0]));
        chk("miss0",   32'(em0), 32'(m_em[0]));
        chk("tready1", 32'(tr1), 32'(m_tr[1]));
        chk("locked1", 32'(lk1), 32'(m_lk[1]));
        chk("done1",   32'(fd1), 32'(m_fd[1]));
        chk("sig1",    fs1,      m_fs[1]);
        chk("fcount1", 32'(fc1), 32'(m_fc[1]));
        chk("ecount1", 32'(ec1), 32'(m_ec[1]));
        chk("early1",  32'(ee1), 32'(m_ee[1]));
        chk("miss1",   32'(em1), 32'(m_em[1]));
    endtask

    // one clock: model steps on the edge, outputs checked 1 time unit later
    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic beat0(input logic u, input logic [7:0] d);
        tv0 = 1'b1; tu0 = u; td0 = d;
        cycle();
        tv0 = 1'b0; tu0 = 1'b0;
    endtask

    initial begin
        int p, k, f;
        logic [7:0] data;
        @(negedge clk);

        // reset: outputs zero, tready low then high
        resetn = 1'b0;
        repeat (3) cycle();
        chk("rst_tready", 32'(tr0), 32'd0);
        chk("rst_fcount", 32'(fc0), 32'd0);
        resetn = 1'b1;
        cycle();
        chk("tready_after", 32'(tr0), 32'd1);

        // clean frames, tdata=1: signature 0xFF each frame
        for (int fr = 0; fr < 3; fr++) begin
            for (int b = 0; b < N; b++) beat0(b == 0, 8'd1);
            chk("clean_done", 32'(fd0), 32'd1);
            chk("clean_sig", fs0, 32'h000000FF);
        end
        chk("clean_cnt", 32'(fc0), 32'd3);
        chk("clean_lock", 32'(lk0), 32'd1);
        chk("clean_err", 32'(ec0), 32'd0);

        // early SOF after SOF + 4 beats, then a full frame from the new SOF
        beat0(1'b1, 8'd1);
        repeat (4) beat0(1'b0, 8'd1);
        beat0(1'b1, 8'd1);
        chk("early_pulse", 32'(ee0), 32'd1);
        chk("early_cnt", 32'(ec0), 32'd1);
        repeat (N - 1) beat0(1'b0, 8'd1);
        chk("early_done", 32'(fd0), 32'd1);
        chk("early_sig", fs0, 32'h000000FF);

        // missing SOF: one good frame, then tuser never set
        for (int b = 0; b < N; b++) beat0(b == 0, 8'd1);
        chk("miss_done", 32'(fd0), 32'd1);
        beat0(1'b0, 8'd1);
        chk("miss_pulse", 32'(em0), 32'd1);
        chk("miss_unlock", 32'(lk0), 32'd0);
        repeat (N - 1) beat0(1'b0, 8'd1);
        chk("miss_nodone", 32'(fc0), 32'd5);

        // reset mid-frame, then a clean frame
        for (int b = 0; b < 5; b++) beat0(b == 0, 8'(b));
        resetn = 1'b0;
        repeat (2) cycle();
        resetn = 1'b1;
        cycle();
        for (int b = 0; b < N; b++) beat0(b == 0, 8'($urandom));
        chk("rst_mid_cnt", 32'(fc0), 32'd1);
        chk("rst_mid_err", 32'(ec0), 32'd0);

        // randomized traffic on dut0 with occasional SOF corruption
        p = 0;
        repeat (400) begin
            tv0 = ($urandom_range(0, 3) != 0);
            tu0 = (p == 0) ^ ($urandom_range(0, 19) == 0);
            td0 = 8'($urandom);
            cycle();
            if (m_beat[0]) p = (p + 1) % N;
        end
        tv0 = 1'b0; tu0 = 1'b0;

        // backpressured dut1: held tvalid, ramp frames then random data
        k = 0; f = 0; data = 8'd0;
        repeat (600) begin
            tv1 = 1'b1; tu1 = (k == 0); td1 = data;
            cycle();
            if (m_beat[1]) begin
                k = k + 1;
                if (k == N) begin k = 0; f = f + 1; end
                data = (f < 3) ? 8'(k) : 8'($urandom);
            end
        end
        tv1 = 1'b0;
        chk("stall_err", 32'(ec1), 32'd0);
        chk("stall_frames", 32'(fc1 > 16'd3), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // hard stop in case the stimulus ever stalls
    initial begin
        #2000000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

endmodule
